// File: rtl/core_pkg.sv
// Shared constants and types for the instruction-memory arbitration slice.
package core_pkg;

  localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;
  localparam int unsigned IMEM_DEPTH = 1024;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef struct packed {
    logic valid;
    logic err;
    logic owner;
  } resp_t;

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port preferred on contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // After serving a port, prefer the other one; hold when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction memory between fetch and debug ports with round-robin
// grant, address checking and a one-cycle pipelined response path.
module imem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(IMEM_BASE),
  parameter int unsigned          MEM_DEPTH  = IMEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_err,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // One extra bit so BASE + DEPTH*4 cannot wrap at the top of the address space.
  localparam logic [ADDR_WIDTH:0] LIM_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LIM_HI = LIM_LO + (ADDR_WIDTH+1)'(MEM_DEPTH) * (ADDR_WIDTH+1)'(4);

  logic [1:0]            req_v, gnt;
  logic                  any_gnt, sel_dbg, legal;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  resp_t                 resp_q, resp_d;
  logic                  kill_q, kill_d;
  logic                  if_hit, dbg_hit;

  // Requests are masked during reset so no grant or memory access leaks out.
  assign req_v = {dbg_req, if_req} & {2{reset_n}};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (reset_n),
    .req_i (req_v),
    .gnt_o (gnt)
  );

  assign if_gnt   = gnt[0];
  assign dbg_gnt  = gnt[1];
  assign any_gnt  = |gnt;
  assign sel_dbg  = gnt[1];
  assign gnt_addr = sel_dbg ? dbg_addr : if_addr;

  assign legal = ({1'b0, gnt_addr} >= LIM_LO) && ({1'b0, gnt_addr} < LIM_HI) &&
                 (gnt_addr[1:0] == 2'b00);

  assign mem_en   = any_gnt && legal;
  assign mem_addr = mem_en ? gnt_addr : '0;

  always_comb begin
    resp_d = '0;
    kill_d = 1'b0;
    if (any_gnt) begin
      resp_d.valid = 1'b1;
      resp_d.err   = !legal;
      resp_d.owner = sel_dbg ? REQ_DBG : REQ_IF;
      kill_d       = gnt[0] && if_flush;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q <= '0;
      kill_q <= 1'b0;
    end else begin
      resp_q <= resp_d;
      kill_q <= kill_d;
    end
  end

  // A fetch response is dropped if flushed at grant (kill bit) or at delivery.
  assign if_hit  = resp_q.valid && (resp_q.owner == REQ_IF) && !kill_q && !if_flush;
  assign dbg_hit = resp_q.valid && (resp_q.owner == REQ_DBG);

  assign if_rvalid  = if_hit;
  assign if_err     = if_hit && resp_q.err;
  assign if_rdata   = (if_hit && !resp_q.err) ? mem_rdata : '0;
  assign dbg_rvalid = dbg_hit;
  assign dbg_err    = dbg_hit && resp_q.err;
  assign dbg_rdata  = (dbg_hit && !resp_q.err) ? mem_rdata : '0;

endmodule
